// File: rtl/seg_shift_ctrl.sv
// seg_shift_ctrl
//   Serialises a 64-bit, 8-digit segment pattern into an external display
//   shift chain. The first bit sent is bit 63 and the last is bit 0. Each bit
//   gets one seg_clk period of 2*DIV system clocks. The clock is low for the
//   first half of the period and high for the second half, so the data is
//   stable across the rising edge. A transfer starts when start is high, or
//   periodically when auto_en=1, once REFRESH idle cycles have passed.
//
// Parameters
//   DIV      system clocks per seg_clk half-period (1..255)
//   REFRESH  idle cycles between automatic transfers (>=1)
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   seg_txt   pattern for 8 digits, [7:0] = leftmost digit
//   start     transfer request, only looked at in IDLE
//   auto_en   enables periodic self-started transfers
//   seg_clk   serial shift clock
//   seg_sout  serial data, MSB first
//   seg_pen   display enable, low while shifting
//   seg_clrn  chain clear, active-low, only asserted during reset
//   busy      transfer in progress
//   done      one-cycle pulse after a transfer completes
module seg_shift_ctrl #(
    parameter int DIV     = 2,
    parameter int REFRESH = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] seg_txt,
    input  logic        start,
    input  logic        auto_en,
    output logic        seg_clk,
    output logic        seg_sout,
    output logic        seg_pen,
    output logic        seg_clrn,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        FINISH
    } state_t;

    localparam logic [7:0]  DIV_LAST = 8'(DIV - 1);
    localparam logic [31:0] REF_LAST = 32'(REFRESH - 1);

    state_t      state_q;
    logic [63:0] shreg_q;
    logic [6:0]  bitcnt_q;
    logic [7:0]  divcnt_q;
    logic [31:0] refcnt_q;
    logic        seg_clk_q;
    logic        seg_pen_q;
    logic        seg_clrn_q;
    logic        busy_q;
    logic        done_q;

    logic        trigger_d;
    logic [31:0] refcnt_d;

    // A start request and a refresh event in the same cycle are ORed together.
    // The result is therefore a single transfer.
    always_comb begin
        trigger_d = start || (auto_en && (refcnt_q == REF_LAST));
        refcnt_d  = auto_en ? (refcnt_q + 32'd1) : '0;
    end

    // seg_sout comes straight from the top flop of the shift register.
    // The shift register therefore also serves as the output register.
    // After the last bit it is left unshifted, so the line keeps bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            divcnt_q   <= '0;
            refcnt_q   <= '0;
            seg_clk_q  <= 1'b0;
            seg_pen_q  <= 1'b0;
            seg_clrn_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            seg_clrn_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    done_q    <= 1'b0;
                    seg_clk_q <= 1'b0;
                    if (trigger_d) begin
                        shreg_q   <= seg_txt;
                        refcnt_q  <= '0;
                        bitcnt_q  <= '0;
                        divcnt_q  <= '0;
                        busy_q    <= 1'b1;
                        seg_pen_q <= 1'b0;
                        state_q   <= SHIFT_LO;
                    end else begin
                        refcnt_q  <= refcnt_d;
                        busy_q    <= 1'b0;
                        seg_pen_q <= 1'b1;
                    end
                end
                SHIFT_LO: begin
                    if (divcnt_q == DIV_LAST) begin
                        divcnt_q  <= '0;
                        seg_clk_q <= 1'b1;
                        state_q   <= SHIFT_HI;
                    end else begin
                        divcnt_q <= divcnt_q + 8'd1;
                    end
                end
                SHIFT_HI: begin
                    if (divcnt_q == DIV_LAST) begin
                        divcnt_q  <= '0;
                        seg_clk_q <= 1'b0;
                        bitcnt_q  <= bitcnt_q + 7'd1;
                        if (bitcnt_q == 7'd63) begin
                            state_q <= FINISH;
                        end else begin
                            shreg_q <= {shreg_q[62:0], 1'b0};
                            state_q <= SHIFT_LO;
                        end
                    end else begin
                        divcnt_q <= divcnt_q + 8'd1;
                    end
                end
                FINISH: begin
                    busy_q    <= 1'b0;
                    seg_pen_q <= 1'b1;
                    done_q    <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign seg_clk  = seg_clk_q;
    assign seg_sout = shreg_q[63];
    assign seg_pen  = seg_pen_q;
    assign seg_clrn = seg_clrn_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
